hazard_sb: RTL and testbench
============================

# hazard_sb

Pipeline hazard and scoreboard unit for the 5-stage MIPS core (F/D/E/M/W). It does three things:
- generates operand forwarding selects for the D-stage branch comparator and the E-stage ALU;
- detects load-use and branch/jump-register hazards;
- tracks a non-blocking multiply/divide unit (MDU), so the pipeline keeps issuing while a mult/div runs and stalls only when HI/LO is read or a second MDU op issues early.

It sits beside the datapath and drives the F/D stall and E flush controls.

## Interface
Parameters:
- REG_AW, 5: register-index width.
- MUL_LAT, 2: multiply latency in cycles (≥1).
- DIV_LAT, 32: divide latency in cycles (≥1, ≥MUL_LAT).

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- rsD, rtD  in  REG_AW  D-stage source registers.
- branchD  in  1  D holds a conditional branch.
- jrD  in  1  D holds jr/jalr.
- hiloreadD  in  1  D holds mfhi/mflo.
- mduopD  in  1  D holds mult/multu/div/divu/mthi/mtlo.
- rsE, rtE, writeregE  in  REG_AW  E-stage registers.
- regwriteE, memtoregE  in  1  E-stage controls.
- mdu_startE  in  1  E holds an MDU op this cycle.
- mdu_divE  in  1  that op is a divide.
- writeregM  in  REG_AW  M-stage destination.
- regwriteM, memtoregM  in  1  M-stage controls.
- writeregW  in  REG_AW  W-stage destination.
- regwriteW  in  1  W-stage control.
- mdu_cancel  in  1  exception flush; aborts the in-flight MDU op.
- stallF, stallD, flushE  out  1  pipeline controls.
- forwardaD, forwardbD  out  2  D forward select.
- forwardaE, forwardbE  out  2  E forward select.
- mdu_busy  out  1  MDU op in flight (registered).
- mdu_done  out  1  one-cycle pulse; HI/LO is written at the end of this cycle.

## Operation
- **Forward codes**
  - 00: register file.
  - 01: W.
  - 10: M.
- **Forwarding priority**
  - Priority is M over W.
  - No forwarding for register 0.
  - D selects use the same M/W rule as E.
- **lwstall**
  - Condition: memtoregE & writeregE≠0 & (writeregE==rsD | writeregE==rtD).
- **brstall**
  - Condition: (branchD | jrD) & [ (regwriteE & writeregE≠0 & match E) | (memtoregM & writeregM≠0 & match M) ].
- **mdustall**
  - Condition: (hiloreadD | mduopD) & mdu_busy & ~mdu_done.
- **Stall outputs**
  - stallD = lwstall | brstall | mdustall.
  - stallF = stallD.
  - flushE = stallD, which inserts a bubble; E never stalls.
- **MDU tracker FSM**, states IDLE and BUSY, down-counter cnt of width $clog2(DIV_LAT):
  - IDLE + mdu_startE: load cnt = (mdu_divE ? DIV_LAT : MUL_LAT) − 1, go to BUSY.
  - BUSY, cnt≠0: decrement.
  - BUSY, cnt==0: mdu_done=1; go to IDLE, or reload and stay BUSY if mdu_startE is high in the same cycle.
  - BUSY + mdu_startE while cnt≠0 cannot occur, because mdustall prevents it. The tracker ignores the start, and the bench asserts it never happens.
  - mdu_cancel has the highest priority: next state IDLE, cnt=0, and any same-cycle start is dropped.
- mdu_busy = (state==BUSY).
- mdu_done = BUSY & cnt==0 (combinational from registered state).

## Timing
- All stall and forward outputs are combinational from the inputs and the registered tracker state. No delay annotations.
- MDU start sampled at edge t: mdu_busy is high for cycles t+1 … t+LAT, and mdu_done is high in cycle t+LAT.
- An mfhi held in D during the mdu_done cycle is released and reads HI/LO in E next cycle.
- Reset (asynchronous, resetn low): state IDLE, cnt 0, mdu_busy 0, mdu_done 0, perf counters 0. Combinational outputs follow their inputs.
- Reset asserted mid-operation abandons the op with no done pulse.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds three 32-bit outputs.
  - perf_lw: counts cycles with lwstall.
  - perf_br: counts cycles with brstall & ~lwstall.
  - perf_mdu: counts cycles with mdustall & ~lwstall & ~brstall.
  - Each counts exactly one cause per stall cycle, wraps modulo 2^32, and clears on reset.
- Not defined: ports and counters are absent; all other behaviour is identical.

## Structure
- hazard_pkg:
  - FWD_RF/FWD_W/FWD_M codes.
  - MDU state enum {MDU_IDLE, MDU_BUSY}.
  - Counter-width function.
- Sub-module mdu_tracker:
  - Contains the FSM, counter, mdu_busy and mdu_done.
  - Parameters MUL_LAT and DIV_LAT.
- hazard_sb holds the forwarding, stall logic and optional perf counters.

## Test plan
- Load-use: lw $5 in E (memtoregE=1, writeregE=5), rsD=5 → stallD=stallF=flushE=1. Next cycle with writeregM=5, regwriteM=1, rsE=5 → forwardaE=10.
- Branch: beq in D with rtD=7, regwriteE=1, writeregE=7 → stallD=1. Next cycle (regwriteM=1, writeregM=7, memtoregM=0) → stallD=0, forwardbD=10. With writeregE=0 instead → no stall.
- Divide: mdu_startE=1, mdu_divE=1 at t; mfhi in D from t+1 → mdu_busy high for t+1…t+32, stallD=1 for t+1…t+31, mdu_done=1 and stallD=0 at t+32.
- Back-to-back: mult at t (MUL_LAT=2), second mult in D at t+1 → stalled at t+1; released at t+2 (done). Start at t+3 → busy t+4…t+5.
- Cancel/reset: mdu_cancel at t+5 of a divide → mdu_busy=0 at t+6, no mdu_done. resetn low mid-divide → mdu_busy=0 immediately.
- Perf (macro on): 3 lwstall cycles + 2 brstall cycles → perf_lw=3, perf_br=2, perf_mdu=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/scoreboard unit: forward-select codes,
// MDU tracker state type and the tracker counter-width helper.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mduStateT;

  // Never returns zero, so a latency of 1 still gets a legal 1-bit counter.
  function automatic int cntWidth(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mdu_tracker.sv
// Tracks one in-flight multiply/divide: a down-counter loaded on start that
// raises mdu_done on its last cycle. mdu_cancel aborts the op unconditionally.
module mdu_tracker
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic mdu_startE,
  input  logic mdu_divE,
  input  logic mdu_cancel,
  output logic mdu_busy,
  output logic mdu_done
);

  localparam int CW = cntWidth(DIV_LAT);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  mduStateT state;
  mduStateT stateNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic [CW-1:0] startLoad;

  assign startLoad = mdu_divE ? DIV_LOAD : MUL_LOAD;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // A start while the counter is still running cannot legally reach us,
  // so it is simply ignored; a start on the final cycle chains a new op.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (mdu_cancel) begin
      stateNext = MDU_IDLE;
      cntNext   = '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (mdu_startE) begin
            stateNext = MDU_BUSY;
            cntNext   = startLoad;
          end
        end
        MDU_BUSY: begin
          if (cnt != '0) begin
            cntNext = cnt - CW'(1);
          end else if (mdu_startE) begin
            cntNext = startLoad;
          end else begin
            stateNext = MDU_IDLE;
          end
        end
        default: begin
          stateNext = MDU_IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  always_comb begin
    mdu_busy = (state == MDU_BUSY);
    mdu_done = (state == MDU_BUSY) && (cnt == '0);
  end

endmodule

// File: rtl/hazard_sb.sv
// Hazard and scoreboard unit for the 5-stage core: forwarding selects, stall/flush
// generation and MDU tracking. Define HAZARD_PERF_CNT_EN to add stall-cause counters.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              branchD,
  input  logic              jrD,
  input  logic              hiloreadD,
  input  logic              mduopD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic              regwriteE,
  input  logic              memtoregE,
  input  logic              mdu_startE,
  input  logic              mdu_divE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteW,
  input  logic              mdu_cancel,
  output logic              stallF,
  output logic              stallD,
  output logic              flushE,
  output logic [1:0]        forwardaD,
  output logic [1:0]        forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic              mdu_busy,
  output logic              mdu_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_lw,
  output logic [31:0]       perf_br,
  output logic [31:0]       perf_mdu
`endif
);

  logic lwStall;
  logic brStall;
  logic mduStall;
  logic matchE;
  logic matchM;

  // M wins over W because it holds the younger write; $0 is never forwarded.
  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] wrM,
    input logic              rwM,
    input logic [REG_AW-1:0] wrW,
    input logic              rwW
  );
    if (src != '0 && rwM && wrM == src) return FWD_M;
    if (src != '0 && rwW && wrW == src) return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    forwardaD = fwdSel(rsD, writeregM, regwriteM, writeregW, regwriteW);
    forwardbD = fwdSel(rtD, writeregM, regwriteM, writeregW, regwriteW);
    forwardaE = fwdSel(rsE, writeregM, regwriteM, writeregW, regwriteW);
    forwardbE = fwdSel(rtE, writeregM, regwriteM, writeregW, regwriteW);
  end

  mdu_tracker #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) uTracker (
    .clk       (clk),
    .resetn    (resetn),
    .mdu_startE(mdu_startE),
    .mdu_divE  (mdu_divE),
    .mdu_cancel(mdu_cancel),
    .mdu_busy  (mdu_busy),
    .mdu_done  (mdu_done)
  );

  // The branch comparator sits in D, so an ALU result in E or a load in M
  // is not yet available to it.
  always_comb begin
    matchE   = (writeregE != '0) && (writeregE == rsD || writeregE == rtD);
    matchM   = (writeregM != '0) && (writeregM == rsD || writeregM == rtD);
    lwStall  = memtoregE && matchE;
    brStall  = (branchD || jrD) && ((regwriteE && matchE) || (memtoregM && matchM));
    mduStall = (hiloreadD || mduopD) && mdu_busy && !mdu_done;
    stallD   = lwStall || brStall || mduStall;
    stallF   = stallD;
    flushE   = stallD;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Each stall cycle is charged to exactly one cause, load-use first.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lw  <= '0;
      perf_br  <= '0;
      perf_mdu <= '0;
    end else begin
      if (lwStall) perf_lw <= perf_lw + 32'd1;
      if (brStall && !lwStall) perf_br <= perf_br + 32'd1;
      if (mduStall && !lwStall && !brStall) perf_mdu <= perf_mdu + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Self-checking bench for hazard_sb: directed scenarios plus randomized traffic
// checked against an interval-based MDU model. Honours HAZARD_PERF_CNT_EN.
module tb_hazard_sb;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic       clk;
  logic       resetn;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       branchD, jrD, hiloreadD, mduopD;
  logic       regwriteE, memtoregE, mdu_startE, mdu_divE;
  logic       regwriteM, memtoregM, regwriteW, mdu_cancel;
  logic       stallF, stallD, flushE, mdu_busy, mdu_done;
  logic [1:0] forwardaD, forwardbD, forwardaE, forwardbE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lw, perf_br, perf_mdu;
`endif

  int totalChecks = 0;
  int badChecks   = 0;
  int cyc         = 0;
  int busyFrom    = 1;
  int busyTo      = 0;
  int unsigned pLw = 0, pBr = 0, pMdu = 0;

  hazard_sb #(
    .REG_AW (5),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rsD       (rsD),
    .rtD       (rtD),
    .branchD   (branchD),
    .jrD       (jrD),
    .hiloreadD (hiloreadD),
    .mduopD    (mduopD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeregE (writeregE),
    .regwriteE (regwriteE),
    .memtoregE (memtoregE),
    .mdu_startE(mdu_startE),
    .mdu_divE  (mdu_divE),
    .writeregM (writeregM),
    .regwriteM (regwriteM),
    .memtoregM (memtoregM),
    .writeregW (writeregW),
    .regwriteW (regwriteW),
    .mdu_cancel(mdu_cancel),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushE    (flushE),
    .forwardaD (forwardaD),
    .forwardbD (forwardbD),
    .forwardaE (forwardaE),
    .forwardbE (forwardbE),
    .mdu_busy  (mdu_busy),
    .mdu_done  (mdu_done)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_lw   (perf_lw),
    .perf_br   (perf_br),
    .perf_mdu  (perf_mdu)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", tag, cyc, actual, expected);
    end
  endtask

  // The MDU op occupies the closed cycle interval [busyFrom, busyTo].
  function automatic bit modelBusy();
    return (cyc >= busyFrom) && (cyc <= busyTo);
  endfunction

  function automatic bit modelDone();
    return modelBusy() && (cyc == busyTo);
  endfunction

  function automatic logic [1:0] expFwd(input logic [4:0] src);
    if (src != 5'd0 && regwriteM && writeregM == src) return 2'b10;
    if (src != 5'd0 && regwriteW && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic calcStalls(output bit lw, output bit br, output bit md);
    bit hitE, hitM;
    hitE = (writeregE != 5'd0) && (writeregE == rsD || writeregE == rtD);
    hitM = (writeregM != 5'd0) && (writeregM == rsD || writeregM == rtD);
    lw = memtoregE && hitE;
    br = (branchD || jrD) && ((regwriteE && hitE) || (memtoregM && hitM));
    md = (hiloreadD || mduopD) && modelBusy() && !modelDone();
  endtask

  task automatic idleInputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {branchD, jrD, hiloreadD, mduopD, regwriteE, memtoregE} = '0;
    {mdu_startE, mdu_divE, regwriteM, memtoregM, regwriteW, mdu_cancel} = '0;
  endtask

  task automatic checkAll();
    bit lw, br, md;
    #1;
    calcStalls(lw, br, md);
    checkOutput("stallD", 32'(stallD), 32'(lw | br | md));
    checkOutput("stallF", 32'(stallF), 32'(lw | br | md));
    checkOutput("flushE", 32'(flushE), 32'(lw | br | md));
    checkOutput("forwardaD", 32'(forwardaD), 32'(expFwd(rsD)));
    checkOutput("forwardbD", 32'(forwardbD), 32'(expFwd(rtD)));
    checkOutput("forwardaE", 32'(forwardaE), 32'(expFwd(rsE)));
    checkOutput("forwardbE", 32'(forwardbE), 32'(expFwd(rtE)));
    checkOutput("mduBusy", 32'(mdu_busy), 32'(modelBusy()));
    checkOutput("mduDone", 32'(mdu_done), 32'(modelDone()));
    checkOutput("illegalStart", 32'(mdu_startE & mdu_busy & ~mdu_done), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("perfLw", perf_lw, pLw);
    checkOutput("perfBr", perf_br, pBr);
    checkOutput("perfMdu", perf_mdu, pMdu);
`endif
  endtask

  // Advance the model by the clock edge that ends the current cycle.
  task automatic nextCycle();
    bit lw, br, md;
    calcStalls(lw, br, md);
    if (lw) pLw++;
    else if (br) pBr++;
    else if (md) pMdu++;
    if (mdu_cancel) begin
      busyFrom = 1;
      busyTo   = 0;
    end else if (mdu_startE && (!modelBusy() || modelDone())) begin
      busyFrom = cyc + 1;
      busyTo   = cyc + (mdu_divE ? DIV_LAT : MUL_LAT);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    #1;
    busyFrom = 1;
    busyTo   = 0;
    pLw = 0;
    pBr = 0;
    pMdu = 0;
    checkOutput("rstBusy", 32'(mdu_busy), 32'd0);
    checkOutput("rstDone", 32'(mdu_done), 32'd0);
    checkAll();
    @(posedge clk);
    cyc++;
    #3;
    resetn = 1'b1;
  endtask

  task automatic applyStimulus();
    rsD       = 5'($urandom_range(0, 7));
    rtD       = 5'($urandom_range(0, 7));
    rsE       = 5'($urandom_range(0, 7));
    rtE       = 5'($urandom_range(0, 7));
    writeregE = 5'($urandom_range(0, 7));
    writeregM = 5'($urandom_range(0, 7));
    writeregW = 5'($urandom_range(0, 7));
    branchD   = ($urandom_range(0, 3) == 0);
    jrD       = ($urandom_range(0, 7) == 0);
    hiloreadD = ($urandom_range(0, 3) == 0);
    mduopD    = ($urandom_range(0, 5) == 0);
    regwriteE = ($urandom_range(0, 1) == 0);
    memtoregE = ($urandom_range(0, 3) == 0);
    regwriteM = ($urandom_range(0, 1) == 0);
    memtoregM = ($urandom_range(0, 3) == 0);
    regwriteW = ($urandom_range(0, 1) == 0);
    mdu_cancel = ($urandom_range(0, 49) == 0);
    mdu_divE   = ($urandom_range(0, 3) == 0);
    mdu_startE = 1'b0;
    if (!modelBusy() || modelDone()) mdu_startE = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    idleInputs();
    doReset();
    nextCycle();

    // load-use then forward from M
    memtoregE = 1; regwriteE = 1; writeregE = 5; rsD = 5;
    checkAll();
    checkOutput("lwStallD", 32'(stallD), 32'd1);
    checkOutput("lwFlushE", 32'(flushE), 32'd1);
    nextCycle();
    idleInputs();
    writeregM = 5; regwriteM = 1; memtoregM = 1; rsE = 5;
    checkAll();
    checkOutput("lwFwdAE", 32'(forwardaE), 32'd2);
    writeregW = 3; regwriteW = 1; rtE = 3;
    checkAll();
    checkOutput("wFwdBE", 32'(forwardbE), 32'd1);
    writeregM = 0; rsE = 0; writeregW = 0;
    checkAll();
    checkOutput("zeroFwdAE", 32'(forwardaE), 32'd0);
    nextCycle();

    // branch hazard, then forward to D from M, then $0 destination
    idleInputs();
    branchD = 1; rtD = 7; regwriteE = 1; writeregE = 7;
    checkAll();
    checkOutput("brStallD", 32'(stallD), 32'd1);
    nextCycle();
    idleInputs();
    branchD = 1; rtD = 7; regwriteM = 1; writeregM = 7;
    checkAll();
    checkOutput("brRelease", 32'(stallD), 32'd0);
    checkOutput("brFwdBD", 32'(forwardbD), 32'd2);
    nextCycle();
    idleInputs();
    branchD = 1; rtD = 7; regwriteE = 1; writeregE = 0;
    checkAll();
    checkOutput("brZeroReg", 32'(stallD), 32'd0);
    nextCycle();

    // divide with mfhi waiting in D
    idleInputs();
    mdu_startE = 1; mdu_divE = 1;
    checkAll();
    nextCycle();
    idleInputs();
    hiloreadD = 1;
    for (int k = 1; k <= DIV_LAT; k++) begin
      checkAll();
      checkOutput("divBusy", 32'(mdu_busy), 32'd1);
      checkOutput("divStall", 32'(stallD), 32'(k < DIV_LAT));
      checkOutput("divDone", 32'(mdu_done), 32'(k == DIV_LAT));
      nextCycle();
    end
    idleInputs();
    checkAll();
    checkOutput("divIdle", 32'(mdu_busy), 32'd0);

    // back-to-back multiplies
    mdu_startE = 1;
    checkAll();
    nextCycle();
    idleInputs();
    mduopD = 1;
    checkAll();
    checkOutput("b2bStall", 32'(stallD), 32'd1);
    nextCycle();
    checkAll();
    checkOutput("b2bRelease", 32'(stallD), 32'd0);
    checkOutput("b2bDone", 32'(mdu_done), 32'd1);
    nextCycle();
    idleInputs();
    mdu_startE = 1;
    checkAll();
    checkOutput("b2bGap", 32'(mdu_busy), 32'd0);
    nextCycle();
    idleInputs();
    for (int k = 0; k < 3; k++) begin
      checkAll();
      checkOutput("b2bBusy2", 32'(mdu_busy), 32'(k < MUL_LAT));
      nextCycle();
    end

    // cancel at t+5 of a divide
    mdu_startE = 1; mdu_divE = 1;
    checkAll();
    nextCycle();
    idleInputs();
    for (int k = 1; k <= 5; k++) begin
      mdu_cancel = (k == 5);
      checkAll();
      nextCycle();
    end
    idleInputs();
    for (int k = 0; k < 4; k++) begin
      checkAll();
      checkOutput("cancelBusy", 32'(mdu_busy), 32'd0);
      checkOutput("cancelDone", 32'(mdu_done), 32'd0);
      nextCycle();
    end

    // reset mid-divide
    mdu_startE = 1; mdu_divE = 1;
    checkAll();
    nextCycle();
    idleInputs();
    for (int k = 0; k < 3; k++) begin
      checkAll();
      nextCycle();
    end
    doReset();
    nextCycle();
    checkAll();
    checkOutput("postRstBusy", 32'(mdu_busy), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    doReset();
    nextCycle();
    memtoregE = 1; writeregE = 4; rsD = 4;
    for (int k = 0; k < 3; k++) begin
      checkAll();
      nextCycle();
    end
    idleInputs();
    branchD = 1; rtD = 7; regwriteE = 1; writeregE = 7;
    for (int k = 0; k < 2; k++) begin
      checkAll();
      nextCycle();
    end
    idleInputs();
    checkAll();
    checkOutput("perfLwDir", perf_lw, 32'd3);
    checkOutput("perfBrDir", perf_br, 32'd2);
    checkOutput("perfMduDir", perf_mdu, 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      checkAll();
      if ($urandom_range(0, 499) == 0) doReset();
      nextCycle();
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
